branch_resolve_queue: RTL and testbench

Parametrised successor to the ID-stage branch generator for the out-of-order core. Branches and JR/JALR whose operands are still pending on a reservation-station ID (RSID) are held in an in-order circular queue. Each entry snoops the common data bus (CDB) for its missing operands. Entries are resolved strictly in program order, and the resolve port reports the actual direction, the actual target and a mispredict flag against the front-end prediction.

---
 rtl/branch_resolve_queue_pkg.sv | 30 +++
 rtl/branch_resolve_queue_if.sv | 57 +++++
 rtl/branch_resolve_queue_cond_eval.sv | 35 +++
 rtl/branch_resolve_queue.sv | 234 +++++++++++++++++++++++
 tb/tb_branch_resolve_queue.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_queue_pkg.sv
// Shared definitions for the branch resolve queue and the branch condition evaluator.
// Holds the condition encoding, default bus widths and a small helper for operand-2 usage.
// No logic of its own; imported by every file of the block.
package branch_resolve_queue_pkg;

    // Default bus widths for the out-of-order core
    localparam int BRQ_DEPTH      = 8;
    localparam int BRQ_RSID_WIDTH = 4;
    localparam int BRQ_ADDR_WIDTH = 32;
    localparam int BRQ_DATA_WIDTH = 32;
    localparam int COND_WIDTH     = 3;

    // Branch condition encoding; COND_RSVD is treated as never-taken
    typedef enum logic [COND_WIDTH-1:0] {
        COND_EQ   = 3'd0,
        COND_NE   = 3'd1,
        COND_GTZ  = 3'd2,
        COND_LEZ  = 3'd3,
        COND_LTZ  = 3'd4,
        COND_GEZ  = 3'd5,
        COND_JREG = 3'd6,
        COND_RSVD = 3'd7
    } cond_e;

    // Only compare-type branches and register jumps wait on operand 2
    function automatic logic uses_op2(input cond_e cond);
        return (cond == COND_EQ) || (cond == COND_NE) || (cond == COND_JREG);
    endfunction

endpackage

// File: rtl/branch_resolve_queue_if.sv
// Bundle of dispatch, CDB snoop and resolve signals for branch_resolve_queue.
// master = producer/consumer side (front end, CDB, commit), slave = the queue.
// Optional statistics counters appear when BRANCH_RESOLVE_STAT_EN is defined.
interface branch_resolve_queue_if #(
    parameter int DEPTH      = 8,
    parameter int RSID_WIDTH = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  flush;
    logic                  disp_valid;
    logic                  disp_ready;
    logic [2:0]            disp_cond;
    logic [ADDR_WIDTH-1:0] disp_target;
    logic                  disp_pred_taken;
    logic [ADDR_WIDTH-1:0] disp_pred_target;
    logic                  disp_op1_rsid_v;
    logic                  disp_op2_rsid_v;
    logic [DATA_WIDTH-1:0] disp_op1;
    logic [DATA_WIDTH-1:0] disp_op2;
    logic                  cdb_valid;
    logic [RSID_WIDTH-1:0] cdb_rsid;
    logic [DATA_WIDTH-1:0] cdb_data;
    logic                  res_valid;
    logic                  res_ready;
    logic                  res_taken;
    logic [ADDR_WIDTH-1:0] res_target;
    logic                  res_mispredict;
    logic [CW-1:0]         count;
`ifdef BRANCH_RESOLVE_STAT_EN
    logic [31:0]           stat_resolved;
    logic [31:0]           stat_mispredict;
`endif

    modport master (
        output flush, disp_valid, disp_cond, disp_target, disp_pred_taken, disp_pred_target,
        output disp_op1_rsid_v, disp_op2_rsid_v, disp_op1, disp_op2,
        output cdb_valid, cdb_rsid, cdb_data, res_ready,
        input  disp_ready, res_valid, res_taken, res_target, res_mispredict, count
`ifdef BRANCH_RESOLVE_STAT_EN
        , input stat_resolved, stat_mispredict
`endif
    );

    modport slave (
        input  flush, disp_valid, disp_cond, disp_target, disp_pred_taken, disp_pred_target,
        input  disp_op1_rsid_v, disp_op2_rsid_v, disp_op1, disp_op2,
        input  cdb_valid, cdb_rsid, cdb_data, res_ready,
        output disp_ready, res_valid, res_taken, res_target, res_mispredict, count
`ifdef BRANCH_RESOLVE_STAT_EN
        , output stat_resolved, stat_mispredict
`endif
    );

endinterface

// File: rtl/branch_resolve_queue_cond_eval.sv
// Branch condition evaluator: decides taken/not-taken from a condition code and two operands.
// Latency: purely combinational, zero cycles.
// Backpressure: none; shared with the ID-stage generator for already-resolved branches.
module branch_cond_eval
    import branch_resolve_queue_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  cond_e                 cond,
    input  logic [DATA_WIDTH-1:0] op1,
    input  logic [DATA_WIDTH-1:0] op2,
    output logic                  taken
);

    logic op1_neg;
    logic op1_zero;

    // Sign/zero tests on op1, then select by condition; reserved code never branches
    always_comb begin
        op1_neg  = op1[DATA_WIDTH-1];
        op1_zero = (op1 == '0);
        taken    = 1'b0;
        case (cond)
            COND_EQ:   taken = (op1 == op2);
            COND_NE:   taken = (op1 != op2);
            COND_GTZ:  taken = !op1_neg && !op1_zero;
            COND_LEZ:  taken = op1_neg || op1_zero;
            COND_LTZ:  taken = op1_neg;
            COND_GEZ:  taken = !op1_neg;
            COND_JREG: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_queue.sv
// In-order queue of unresolved branches/JREGs that snoops the CDB and resolves in program order.
// Latency: res_valid rises one cycle after the head has no pending operand; one resolve per cycle.
// Backpressure: res_* hold while res_valid && !res_ready; disp_ready drops when the queue is full.
// Optional: BRANCH_RESOLVE_STAT_EN adds saturating resolve/mispredict counters.
module branch_resolve_queue
    import branch_resolve_queue_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int RSID_WIDTH = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    branch_resolve_queue_if.slave bus
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [IW-1:0] IDX_ONE = 1;

    // Operands hold the waiting tag in their low bits while the pending bit is set.
    // The fall-through is fixed at dispatch: the predicted target when predicted
    // not-taken, otherwise zero (the consumer only needs the mispredict flag then).
    typedef struct packed {
        cond_e                 cond;
        logic                  pred_taken;
        logic [ADDR_WIDTH-1:0] target;
        logic [ADDR_WIDTH-1:0] pred_target;
        logic [ADDR_WIDTH-1:0] fallthrough;
        logic [DATA_WIDTH-1:0] op1;
        logic [DATA_WIDTH-1:0] op2;
        logic                  p1;
        logic                  p2;
    } entry_t;

    entry_t                entry_q [DEPTH];
    entry_t                entry_d [DEPTH];
    logic [DEPTH-1:0]      valid_q, valid_d;
    logic [PW-1:0]         head_q, head_d;
    logic [PW-1:0]         tail_q, tail_d;
    logic                  res_valid_q, res_valid_d;
    logic                  res_taken_q, res_taken_d;
    logic [ADDR_WIDTH-1:0] res_target_q, res_target_d;
    logic                  res_mispredict_q, res_mispredict_d;

    logic [IW-1:0]         head_idx;
    logic [IW-1:0]         tail_idx;
    logic [IW-1:0]         sel_idx;
    logic                  full;
    logic                  disp_ready;
    logic                  disp_fire;
    logic                  pop;
    entry_t                new_entry;
    entry_t                sel_entry;
    logic                  sel_ready;
    logic                  sel_taken;
    logic [ADDR_WIDTH-1:0] sel_target;
    logic                  sel_mispredict;

    assign head_idx   = head_q[IW-1:0];
    assign tail_idx   = tail_q[IW-1:0];
    assign full       = (head_q[PW-1] != tail_q[PW-1]) && (head_idx == tail_idx);
    assign disp_ready = !full;
    assign disp_fire  = bus.disp_valid && disp_ready;
    assign pop        = res_valid_q && bus.res_ready;

    assign bus.disp_ready     = disp_ready;
    assign bus.count          = tail_q - head_q;
    assign bus.res_valid      = res_valid_q;
    assign bus.res_taken      = res_taken_q;
    assign bus.res_target     = res_target_q;
    assign bus.res_mispredict = res_mispredict_q;

    // Build the entry being dispatched, folding in a same-cycle CDB broadcast of its tags
    always_comb begin
        logic byp1;
        logic byp2;
        logic use2;
        byp1 = bus.cdb_valid && (bus.disp_op1[RSID_WIDTH-1:0] == bus.cdb_rsid);
        byp2 = bus.cdb_valid && (bus.disp_op2[RSID_WIDTH-1:0] == bus.cdb_rsid);
        use2 = uses_op2(cond_e'(bus.disp_cond));
        new_entry             = '0;
        new_entry.cond        = cond_e'(bus.disp_cond);
        new_entry.pred_taken  = bus.disp_pred_taken;
        new_entry.target      = bus.disp_target;
        new_entry.pred_target = bus.disp_pred_target;
        new_entry.fallthrough = bus.disp_pred_taken ? '0 : bus.disp_pred_target;
        new_entry.p1          = bus.disp_op1_rsid_v && !byp1;
        new_entry.op1         = (bus.disp_op1_rsid_v && byp1) ? bus.cdb_data : bus.disp_op1;
        new_entry.p2          = use2 && bus.disp_op2_rsid_v && !byp2;
        new_entry.op2         = (use2 && bus.disp_op2_rsid_v && byp2) ? bus.cdb_data : bus.disp_op2;
    end

    // Pick the entry that will sit at the head next cycle (head+1 when popping now)
    always_comb begin
        sel_idx   = pop ? (head_idx + IDX_ONE) : head_idx;
        sel_entry = entry_q[sel_idx];
        sel_ready = valid_q[sel_idx] && !sel_entry.p1 && !sel_entry.p2;
    end

    branch_cond_eval #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_cond_eval (
        .cond  (sel_entry.cond),
        .op1   (sel_entry.op1),
        .op2   (sel_entry.op2),
        .taken (sel_taken)
    );

    // Actual next PC and mispredict flag for the selected entry
    always_comb begin
        sel_target = sel_entry.fallthrough;
        if (sel_taken) begin
            sel_target = (sel_entry.cond == COND_JREG) ? ADDR_WIDTH'(sel_entry.op1) : sel_entry.target;
        end
        sel_mispredict = (sel_taken != sel_entry.pred_taken) ||
                         (sel_taken && (sel_target != sel_entry.pred_target));
    end

    // Queue state update: CDB snoop, pop, dispatch; flush overrides everything
    always_comb begin
        entry_d = entry_q;
        valid_d = valid_q;
        head_d  = head_q;
        tail_d  = tail_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.cdb_valid && valid_q[i]) begin
                if (entry_q[i].p1 && (entry_q[i].op1[RSID_WIDTH-1:0] == bus.cdb_rsid)) begin
                    entry_d[i].op1 = bus.cdb_data;
                    entry_d[i].p1  = 1'b0;
                end
                if (entry_q[i].p2 && (entry_q[i].op2[RSID_WIDTH-1:0] == bus.cdb_rsid)) begin
                    entry_d[i].op2 = bus.cdb_data;
                    entry_d[i].p2  = 1'b0;
                end
            end
        end
        if (pop) begin
            valid_d[head_idx] = 1'b0;
            head_d            = head_q + PTR_ONE;
        end
        if (disp_fire) begin
            entry_d[tail_idx] = new_entry;
            valid_d[tail_idx] = 1'b1;
            tail_d            = tail_q + PTR_ONE;
        end
        if (bus.flush) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
        end
    end

    // Resolve register: hold while stalled, otherwise load the next head's result
    always_comb begin
        res_valid_d      = res_valid_q;
        res_taken_d      = res_taken_q;
        res_target_d     = res_target_q;
        res_mispredict_d = res_mispredict_q;
        if (!res_valid_q || pop) begin
            res_valid_d      = sel_ready;
            res_taken_d      = sel_ready && sel_taken;
            res_target_d     = sel_ready ? sel_target : '0;
            res_mispredict_d = sel_ready && sel_mispredict;
        end
        if (bus.flush) begin
            res_valid_d      = 1'b0;
            res_taken_d      = 1'b0;
            res_target_d     = '0;
            res_mispredict_d = 1'b0;
        end
    end

    // State registers; reset drops every entry immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            valid_q          <= '0;
            head_q           <= '0;
            tail_q           <= '0;
            res_valid_q      <= 1'b0;
            res_taken_q      <= 1'b0;
            res_target_q     <= '0;
            res_mispredict_q <= 1'b0;
        end else begin
            entry_q          <= entry_d;
            valid_q          <= valid_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            res_valid_q      <= res_valid_d;
            res_taken_q      <= res_taken_d;
            res_target_q     <= res_target_d;
            res_mispredict_q <= res_mispredict_d;
        end
    end

`ifdef BRANCH_RESOLVE_STAT_EN
    logic [31:0] stat_resolved_q, stat_resolved_d;
    logic [31:0] stat_mispredict_q, stat_mispredict_d;

    assign bus.stat_resolved   = stat_resolved_q;
    assign bus.stat_mispredict = stat_mispredict_q;

    // Saturating counters of accepted resolutions; a flush cancels that cycle's accept
    always_comb begin
        stat_resolved_d   = stat_resolved_q;
        stat_mispredict_d = stat_mispredict_q;
        if (pop && !bus.flush) begin
            if (stat_resolved_q != '1) begin
                stat_resolved_d = stat_resolved_q + 32'd1;
            end
            if (res_mispredict_q && (stat_mispredict_q != '1)) begin
                stat_mispredict_d = stat_mispredict_q + 32'd1;
            end
        end
    end

    // Counters survive flush; only reset clears them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_resolved_q   <= '0;
            stat_mispredict_q <= '0;
        end else begin
            stat_resolved_q   <= stat_resolved_d;
            stat_mispredict_q <= stat_mispredict_d;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue: expected resolutions are queued at dispatch,
// a negedge monitor pops and compares on every accepted resolution.
// Directed vectors with hand-computed results.
module tb_branch_resolve_queue;
    import branch_resolve_queue_pkg::*;

    localparam int DEPTH = 8;
    localparam int RW    = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_resolve_queue_if #(.DEPTH(DEPTH), .RSID_WIDTH(RW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) brq ();

    branch_resolve_queue #(.DEPTH(DEPTH), .RSID_WIDTH(RW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (brq)
    );

    typedef struct {
        logic          taken;
        logic [AW-1:0] target;
        logic          mis;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Fill table: cond, operands, taken target, prediction and hand-derived results
    logic [2:0]  f_cond [8] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
    logic [31:0] f_op1  [8] = '{32'd1, 32'd1, 32'd0, 32'd5, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'd0};
    logic [31:0] f_op2  [8] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] f_tgt  [8] = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 32'h60, 32'h70, 32'h80};
    logic        f_pt   [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] f_pp   [8] = '{32'h14, 32'h20, 32'h30, 32'h44, 32'h54, 32'h64, 32'h74, 32'h84};
    logic        e_tk   [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] e_tgt  [8] = '{32'h14, 32'h20, 32'h0, 32'h40, 32'h50, 32'h64, 32'h74, 32'h84};
    logic        e_mis  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic tk, input logic [31:0] tgt, input logic mis);
        exp_t e;
        e.taken  = tk;
        e.target = tgt;
        e.mis    = mis;
        exp_q.push_back(e);
    endtask

    // Present one dispatch from posedge+1; returns at posedge+1 after acceptance
    task automatic do_disp(input logic [2:0] cond, input logic [31:0] tgt, input logic pt,
                           input logic [31:0] pp, input logic v1, input logic [31:0] o1,
                           input logic v2, input logic [31:0] o2);
        int n = 0;
        brq.disp_cond        = cond;
        brq.disp_target      = tgt;
        brq.disp_pred_taken  = pt;
        brq.disp_pred_target = pp;
        brq.disp_op1_rsid_v  = v1;
        brq.disp_op1         = o1;
        brq.disp_op2_rsid_v  = v2;
        brq.disp_op2         = o2;
        brq.disp_valid       = 1'b1;
        @(negedge clk);
        while (!brq.disp_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            errors++;
            checks++;
            $display("FAIL disp_timeout: disp_ready stayed 0 for %0d cycles, expected 1", n);
        end
        @(posedge clk);
        #1;
        brq.disp_valid = 1'b0;
    endtask

    task automatic cdb_pulse(input logic [3:0] tag, input logic [31:0] data);
        brq.cdb_valid = 1'b1;
        brq.cdb_rsid  = tag;
        brq.cdb_data  = data;
        @(posedge clk);
        #1;
        brq.cdb_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        @(negedge clk);
        while ((brq.count != 0 || brq.res_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout: count=%0d, expected 0", brq.count);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted resolution is compared with the oldest expectation
    always @(negedge clk) begin
        if (!rst && brq.res_valid && brq.res_ready) begin
            if (exp_q.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL unexpected_resolve: target 0x%0h, expected no resolution", brq.res_target);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_taken", 64'(brq.res_taken), 64'(e.taken));
                check("res_target", 64'(brq.res_target), 64'(e.target));
                check("res_mispredict", 64'(brq.res_mispredict), 64'(e.mis));
            end
        end
    end

    initial begin
        brq.flush            = 1'b0;
        brq.disp_valid       = 1'b0;
        brq.disp_cond        = 3'd0;
        brq.disp_target      = '0;
        brq.disp_pred_taken  = 1'b0;
        brq.disp_pred_target = '0;
        brq.disp_op1_rsid_v  = 1'b0;
        brq.disp_op2_rsid_v  = 1'b0;
        brq.disp_op1         = '0;
        brq.disp_op2         = '0;
        brq.cdb_valid        = 1'b0;
        brq.cdb_rsid         = '0;
        brq.cdb_data         = '0;
        brq.res_ready        = 1'b1;

        // Reset state
        #12;
        check("rst_count", 64'(brq.count), 64'd0);
        check("rst_disp_ready", 64'(brq.disp_ready), 64'd1);
        check("rst_res_valid", 64'(brq.res_valid), 64'd0);
        check("rst_res_taken", 64'(brq.res_taken), 64'd0);
        check("rst_res_target", 64'(brq.res_target), 64'd0);
        check("rst_res_mispredict", 64'(brq.res_mispredict), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: BEQ 5==5 ready, predicted taken to 0x100
        push_exp(1'b1, 32'h100, 1'b0);
        do_disp(3'd0, 32'h100, 1'b1, 32'h100, 1'b0, 32'd5, 1'b0, 32'd5);
        @(negedge clk);
        check("t1_latency_not_yet", 64'(brq.res_valid), 64'd0);
        check("t1_count", 64'(brq.count), 64'd1);
        @(negedge clk);
        check("t1_res_valid", 64'(brq.res_valid), 64'd1);
        wait_drain();

        // 2a: BNE op1 pending on tag 3, CDB delivers 7 two cycles later
        push_exp(1'b0, 32'h204, 1'b0);
        do_disp(3'd1, 32'h300, 1'b0, 32'h204, 1'b1, 32'd3, 1'b0, 32'd7);
        @(posedge clk);
        #1;
        cdb_pulse(4'd3, 32'd7);
        @(negedge clk);
        check("t2_not_before_capture", 64'(brq.res_valid), 64'd0);
        @(negedge clk);
        check("t2_res_valid", 64'(brq.res_valid), 64'd1);
        wait_drain();

        // 2b: same with data 8 -> taken, mispredicted
        push_exp(1'b1, 32'h300, 1'b1);
        do_disp(3'd1, 32'h300, 1'b0, 32'h204, 1'b1, 32'd3, 1'b0, 32'd7);
        @(posedge clk);
        #1;
        cdb_pulse(4'd3, 32'd8);
        wait_drain();

        // 3: JREG with dispatch-cycle bypass of tag 2 = 0x400
        push_exp(1'b1, 32'h400, 1'b0);
        brq.cdb_valid = 1'b1;
        brq.cdb_rsid  = 4'd2;
        brq.cdb_data  = 32'h400;
        do_disp(3'd6, 32'h999, 1'b1, 32'h400, 1'b1, 32'd2, 1'b0, 32'd0);
        brq.cdb_valid = 1'b0;
        wait_drain();

        // 5: in-order: blocked BEQ head, ready GEZ behind it (op2 tag ignored)
        push_exp(1'b1, 32'h440, 1'b1);
        push_exp(1'b1, 32'h500, 1'b0);
        do_disp(3'd0, 32'h440, 1'b0, 32'h444, 1'b1, 32'd5, 1'b0, 32'd1);
        do_disp(3'd5, 32'h500, 1'b1, 32'h500, 1'b0, 32'd0, 1'b1, 32'd9);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_head_blocks", 64'(brq.res_valid), 64'd0);
        end
        check("t5_count", 64'(brq.count), 64'd2);
        @(posedge clk);
        #1;
        cdb_pulse(4'd5, 32'd1);
        wait_drain();

        // 4: fill with consumer stalled
        brq.res_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            push_exp(e_tk[i], e_tgt[i], e_mis[i]);
            do_disp(f_cond[i], f_tgt[i], f_pt[i], f_pp[i], 1'b0, f_op1[i], 1'b0, f_op2[i]);
        end
        @(negedge clk);
        check("t4_full_count", 64'(brq.count), 64'd8);
        check("t4_full_disp_ready", 64'(brq.disp_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t4_hold_valid", 64'(brq.res_valid), 64'd1);
            check("t4_hold_target", 64'(brq.res_target), 64'h14);
            check("t4_hold_taken", 64'(brq.res_taken), 64'd0);
        end
        // Dispatch while full in the same cycle as a pop: dispatch must be refused
        @(posedge clk);
        #1;
        brq.disp_cond       = 3'd6;
        brq.disp_op1_rsid_v = 1'b0;
        brq.disp_op2_rsid_v = 1'b0;
        brq.disp_valid      = 1'b1;
        brq.res_ready       = 1'b1;
        @(posedge clk);
        #1;
        brq.disp_valid = 1'b0;
        brq.res_ready  = 1'b0;
        @(negedge clk);
        check("t4_full_pop_count", 64'(brq.count), 64'd7);
        brq.res_ready = 1'b1;
        wait_drain();

        // 4b: second fill wraps the pointers, consumer ready
        for (int i = 0; i < 8; i++) begin
            push_exp(e_tk[i], e_tgt[i], e_mis[i]);
            do_disp(f_cond[i], f_tgt[i], f_pt[i], f_pp[i], 1'b0, f_op1[i], 1'b0, f_op2[i]);
        end
        wait_drain();

        // 6: flush with 5 entries queued and a dispatch pending
        brq.res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            do_disp(f_cond[i], f_tgt[i], f_pt[i], f_pp[i], 1'b0, f_op1[i], 1'b0, f_op2[i]);
        end
        @(negedge clk);
        check("t6_pre_flush_count", 64'(brq.count), 64'd5);
        @(posedge clk);
        #1;
        brq.flush      = 1'b1;
        brq.disp_valid = 1'b1;
        @(posedge clk);
        #1;
        brq.flush      = 1'b0;
        brq.disp_valid = 1'b0;
        @(negedge clk);
        check("t6_flush_count", 64'(brq.count), 64'd0);
        check("t6_flush_res_valid", 64'(brq.res_valid), 64'd0);
        check("t6_flush_disp_ready", 64'(brq.disp_ready), 64'd1);
        check("t6_flush_res_target", 64'(brq.res_target), 64'd0);

        // 6b: asynchronous reset mid-stream
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            do_disp(f_cond[i], f_tgt[i], f_pt[i], f_pp[i], 1'b0, f_op1[i], 1'b0, f_op2[i]);
        end
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_count", 64'(brq.count), 64'd0);
        check("t6_rst_res_valid", 64'(brq.res_valid), 64'd0);
        check("t6_rst_disp_ready", 64'(brq.disp_ready), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        brq.res_ready = 1'b1;

        // Recovery after reset
        push_exp(1'b1, 32'h100, 1'b0);
        do_disp(3'd0, 32'h100, 1'b1, 32'h100, 1'b0, 32'd5, 1'b0, 32'd5);
        wait_drain();

        check("leftover_expectations", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
